// File: rtl/aclk_pkg.sv
// Shared constants, state encoding and time-range helper for the alarm entry block.
package aclk_pkg;

  localparam int         DIGIT_W    = 4;
  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] KEY_ALARM     = 4'hA;
  localparam logic [3:0] KEY_CLEAR     = 4'hB;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

  // Latest legal alarm time is 23:59.
  localparam logic [3:0] MAX_MS_HR       = 4'd2;
  localparam logic [3:0] MAX_LS_HR_AT_2X = 4'd3;
  localparam logic [3:0] MAX_MS_MIN      = 4'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_ENTRY, ST_LOAD} state_t;

  function automatic logic time_in_range(input logic [3:0] ms_hr,
                                         input logic [3:0] ls_hr,
                                         input logic [3:0] ms_min);
    return (ms_hr <= MAX_MS_HR) &&
           ((ms_hr != MAX_MS_HR) || (ls_hr <= MAX_LS_HR_AT_2X)) &&
           (ms_min <= MAX_MS_MIN);
  endfunction

endpackage

// File: rtl/aclk_entry_timer.sv
// Inactivity counter: cleared by clear, counts tick, saturates at TIMEOUT_SEC.
module aclk_entry_timer #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_SEC + 1);
  localparam logic [W-1:0] CNT_MAX  = W'(TIMEOUT_SEC);
  localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT_SEC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt <= '0;
    else if (clear)                cnt <= '0;
    else if (tick && cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  // A clear in the same cycle wins, so a key press drops a coincident tick.
  assign expire = tick && !clear && (cnt >= CNT_LAST);

endmodule

// File: rtl/aclk_alarm_entry.sv
// Keypad alarm entry: gathers HH:MM digits, validates on ALARM and pulses load_new_a.
// Define ACLK_ENTRY_RANGE_CHECK_EN to reject commits later than 23:59.
module aclk_alarm_entry #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       one_second,
  output logic [3:0] new_alarm_ms_hr,
  output logic [3:0] new_alarm_ls_hr,
  output logic [3:0] new_alarm_ms_min,
  output logic [3:0] new_alarm_ls_min,
  output logic       load_new_a,
  output logic       entry_busy,
  output logic       entry_err
);
  import aclk_pkg::*;

  state_t state, state_n;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digs, digs_n;
  logic [2:0] cnt, cnt_n;
  logic       err_q, err_n;
  logic       tmr_clr, tmr_tick, expire;
  logic       is_digit, commit_ok;

  assign is_digit = key <= KEY_MAX_DIGIT;
  assign tmr_tick = one_second && (state == ST_ENTRY);

`ifdef ACLK_ENTRY_RANGE_CHECK_EN
  assign commit_ok = (cnt == 3'd4) && time_in_range(digs[3], digs[2], digs[1]);
`else
  assign commit_ok = (cnt == 3'd4);
`endif

  aclk_entry_timer #(.TIMEOUT_SEC(TIMEOUT_SEC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clr),
    .tick   (tmr_tick),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      digs  <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      digs  <= digs_n;
      cnt   <= cnt_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    digs_n  = digs;
    cnt_n   = cnt;
    err_n   = 1'b0;
    tmr_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_valid && is_digit) begin
          digs_n    = '0;
          digs_n[0] = key;
          cnt_n     = 3'd1;
          tmr_clr   = 1'b1;
          state_n   = ST_ENTRY;
        end else if (key_valid && key == KEY_ALARM) begin
          err_n = 1'b1;
        end
      end
      ST_ENTRY: begin
        if (key_valid && is_digit) begin
          // Rolling window: the last four digits typed are the candidate time.
          digs_n  = {digs[NUM_DIGITS-2:0], key};
          cnt_n   = (cnt == 3'd4) ? cnt : cnt + 3'd1;
          tmr_clr = 1'b1;
        end else if (key_valid && key == KEY_CLEAR) begin
          digs_n  = '0;
          cnt_n   = '0;
          tmr_clr = 1'b1;
          state_n = ST_IDLE;
        end else if (key_valid && key == KEY_ALARM) begin
          tmr_clr = 1'b1;
          if (commit_ok) begin
            state_n = ST_LOAD;
          end else begin
            err_n   = 1'b1;
            cnt_n   = '0;
            state_n = ST_IDLE;
          end
        end else if (expire) begin
          digs_n  = '0;
          cnt_n   = '0;
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign new_alarm_ms_hr  = digs[3];
  assign new_alarm_ls_hr  = digs[2];
  assign new_alarm_ms_min = digs[1];
  assign new_alarm_ls_min = digs[0];
  assign load_new_a       = (state == ST_LOAD);
  assign entry_busy       = (state == ST_ENTRY);
  assign entry_err        = err_q;

endmodule

// File: tb/tb_aclk_alarm_entry.sv
// Directed plus random key/tick stimulus against a digit-list reference model of alarm entry.
module tb_aclk_alarm_entry;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst, key_valid, one_second;
  logic [3:0] key;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       load_new_a, entry_busy, entry_err;

  aclk_alarm_entry #(.TIMEOUT_SEC(T)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key(key), .one_second(one_second),
    .new_alarm_ms_hr(ms_hr), .new_alarm_ls_hr(ls_hr),
    .new_alarm_ms_min(ms_min), .new_alarm_ls_min(ls_min),
    .load_new_a(load_new_a), .entry_busy(entry_busy), .entry_err(entry_err)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 open entry, 2 load cycle.
  int         m_mode;
  int         m_digs[$];
  int         m_disp[4];
  int         m_idle_ticks;
  bit         m_err;
  int         n_pass = 0, n_total = 0, n_fail = 0;

  function automatic bit time_ok();
    int n, hh, mm;
    n = m_digs.size();
    if (n < 4) return 0;
`ifdef ACLK_ENTRY_RANGE_CHECK_EN
    hh = 10 * m_digs[n-4] + m_digs[n-3];
    mm = 10 * m_digs[n-2] + m_digs[n-1];
    return (hh <= 23) && (mm <= 59);
`else
    hh = 0; mm = 0;
    return 1;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_digs.delete(); m_idle_ticks = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_disp[i] = 0;
  endtask

  task automatic show_last4();
    int n;
    n = m_digs.size();
    for (int i = 0; i < 4; i++) m_disp[i] = (n - 4 + i >= 0) ? m_digs[n-4+i] : 0;
  endtask

  task automatic model_step(bit kv, int k, bit tk);
    bit accepted;
    accepted = kv && (k <= 9 || k == 10 || k == 11);
    m_err = 0;
    case (m_mode)
      2: m_mode = 0;
      0: if (kv && k <= 9) begin
           m_digs.delete(); m_digs.push_back(k); show_last4();
           m_idle_ticks = 0; m_mode = 1;
         end else if (kv && k == 10) m_err = 1;
      default: begin
        if (accepted) m_idle_ticks = 0;
        if (accepted && k <= 9) begin
          m_digs.push_back(k); show_last4();
        end else if (accepted && k == 11) begin
          m_digs.delete(); for (int i = 0; i < 4; i++) m_disp[i] = 0; m_mode = 0;
        end else if (accepted && k == 10) begin
          if (time_ok()) m_mode = 2;
          else begin m_err = 1; m_mode = 0; end
          m_digs.delete();
        end else if (tk) begin
          m_idle_ticks++;
          if (m_idle_ticks == T) begin
            for (int i = 0; i < 4; i++) m_disp[i] = 0; m_mode = 0;
          end
        end
      end
    endcase
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [15:0] e_dig;
    e_dig = {m_disp[0][3:0], m_disp[1][3:0], m_disp[2][3:0], m_disp[3][3:0]};
    chk({tag, "_digits"}, {ms_hr, ls_hr, ms_min, ls_min}, e_dig);
    chk({tag, "_load"}, {15'd0, load_new_a}, {15'd0, m_mode == 2});
    chk({tag, "_busy"}, {15'd0, entry_busy}, {15'd0, m_mode == 1});
    chk({tag, "_err"}, {15'd0, entry_err}, {15'd0, m_err});
  endtask

  task automatic step(bit kv, int k, bit tk, string tag);
    key_valid = kv; key = 4'(k); one_second = tk;
    @(posedge clk);
    model_step(kv, k, tk);
    #1;
    key_valid = 0; one_second = 0;
    check_all(tag);
  endtask

  task automatic keys(int ks[$], string tag);
    foreach (ks[i]) step(1, ks[i], 0, tag);
  endtask

  initial begin
    rst = 1; key_valid = 0; key = 0; one_second = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 0;
    step(0, 0, 0, "idle");

    // 1: straight commit of 12:34
    keys('{1, 2, 3, 4}, "t1");
    step(1, 10, 0, "t1_alarm");
    chk("t1_load_const", {15'd0, load_new_a}, 16'd1);
    chk("t1_digits_const", {ms_hr, ls_hr, ms_min, ls_min}, 16'h1234);
    step(0, 0, 0, "t1_after");
    chk("t1_load_drop", {15'd0, load_new_a}, 16'd0);

    // 2: short entry rejected, then 07:30
    keys('{1, 2}, "t2");
    step(1, 10, 0, "t2_alarm");
    chk("t2_err_const", {15'd0, entry_err}, 16'd1);
    step(0, 0, 0, "t2_gap");
    keys('{0, 7, 3, 0}, "t2b");
    step(1, 10, 0, "t2b_alarm");
    chk("t2b_digits_const", {ms_hr, ls_hr, ms_min, ls_min}, 16'h0730);
    step(0, 0, 0, "t2b_after");

    // 3: rolling window 34:56, then 23:59
    keys('{1, 2, 3, 4, 5, 6}, "t3");
    step(1, 10, 0, "t3_alarm");
`ifdef ACLK_ENTRY_RANGE_CHECK_EN
    chk("t3_err_const", {15'd0, entry_err}, 16'd1);
`else
    chk("t3_load_const", {15'd0, load_new_a}, 16'd1);
`endif
    step(0, 0, 0, "t3_gap");
    keys('{2, 3, 5, 9}, "t3b");
    step(1, 10, 0, "t3b_alarm");
    chk("t3b_load_const", {15'd0, load_new_a}, 16'd1);
    step(0, 0, 0, "t3b_after");

    // 4: timeout, and key coincident with tick T-1 restarting the count
    keys('{0, 9}, "t4");
    for (int i = 0; i < T - 1; i++) step(0, 0, 1, "t4_tick");
    chk("t4_busy_before", {15'd0, entry_busy}, 16'd1);
    step(0, 0, 1, "t4_last");
    chk("t4_timeout", {15'd0, entry_busy}, 16'd0);
    keys('{0, 9}, "t4b");
    for (int i = 0; i < T - 2; i++) step(0, 0, 1, "t4b_tick");
    step(1, 5, 1, "t4b_keytick");
    for (int i = 0; i < T - 1; i++) step(0, 0, 1, "t4b_ext");
    chk("t4b_extended", {15'd0, entry_busy}, 16'd1);
    step(0, 0, 1, "t4b_last");
    chk("t4b_timeout", {15'd0, entry_busy}, 16'd0);

    // 5: CLEAR then a one-digit commit
    keys('{1, 2, 11}, "t5");
    chk("t5_clear_idle", {15'd0, entry_busy}, 16'd0);
    keys('{4, 10}, "t5b");
    chk("t5b_err_const", {15'd0, entry_err}, 16'd1);
    step(0, 0, 0, "t5_after");

    // 6: asynchronous reset mid-entry
    keys('{1, 2, 3}, "t6");
    #2 rst = 1;
    #1 model_reset();
    check_all("t6_async_rst");
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    key_valid = 0;
    step(1, 10, 0, "t6_alarm");
    chk("t6_err_const", {15'd0, entry_err}, 16'd1);

    // Random phase
    for (int i = 0; i < 2500; i++) begin
      int r, k;
      bit kv, tk;
      kv = ($urandom_range(0, 2) == 0);
      r  = $urandom_range(0, 15);
      if (r < 11)      k = $urandom_range(0, 9);
      else if (r < 13) k = 10;
      else if (r < 14) k = 11;
      else             k = $urandom_range(12, 15);
      tk = ($urandom_range(0, 5) == 0);
      step(kv, k, tk, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
